// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard sequencer for the 5-stage RISC_TOY pipeline.
// Tracks the destination registers of the EX/MEM/WB instructions and derives
// forwarding selects, load-use stalls, redirect flushes and memory freezes.
// All control outputs are combinational; the scoreboard updates on each edge.

// Per-operand forwarding select and load-use detect against the scoreboard.
module phc_fwd_sel #(
   parameter int unsigned AW      = 5,
   parameter bit          R0_ZERO = 1'b0
) (
   input  logic          en,
   input  logic          rs_use,
   input  logic [AW-1:0] rs,
   input  logic          x_v,
   input  logic          x_we,
   input  logic          x_ld,
   input  logic [AW-1:0] x_rd,
   input  logic          m_v,
   input  logic          m_we,
   input  logic [AW-1:0] m_rd,
   input  logic          w_v,
   input  logic          w_we,
   input  logic [AW-1:0] w_rd,
   output logic [1:0]    sel,
   output logic          lu_hit
);
   logic x_match, m_match, w_match;

   // rd==0 can be excluded as a hazard source when r0 is hardwired to zero
   assign x_match = rs_use && x_v && x_we && (x_rd == rs) && !(R0_ZERO && x_rd == '0);
   assign m_match = rs_use && m_v && m_we && (m_rd == rs) && !(R0_ZERO && m_rd == '0);
   assign w_match = rs_use && w_v && w_we && (w_rd == rs) && !(R0_ZERO && w_rd == '0);

   // a load in EX has no result yet; it can only stall, never forward
   assign lu_hit = x_match && x_ld;

   // youngest producer wins; slots with we=0 never match so older ones are seen
   always_comb begin
      sel = 2'd0;
      if (en) begin
         if (x_match && !x_ld) sel = 2'd1;
         else if (m_match)     sel = 2'd2;
         else if (w_match)     sel = 2'd3;
      end
   end
endmodule

module pipe_hazard_ctrl #(
   parameter int unsigned AW      = 5,
   parameter int unsigned CW      = 16,
   parameter bit          R0_ZERO = 1'b0
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs1,
   input  logic          id_rs1_use,
   input  logic [AW-1:0] id_rs2,
   input  logic          id_rs2_use,
   input  logic [AW-1:0] id_rd,
   input  logic          id_rd_we,
   input  logic          id_is_load,
   input  logic          ex_redirect,
   input  logic          mem_busy,
   output logic          stall_if,
   output logic          stall_id,
   output logic          flush_id,
   output logic          bubble_ex,
   output logic          pc_sel,
   output logic [1:0]    fwd_a,
   output logic [1:0]    fwd_b,
   output logic [CW-1:0] stall_cnt,
   output logic [CW-1:0] flush_cnt
);
   typedef struct packed {
      logic          valid;
      logic [AW-1:0] rd;
      logic          we;
   } slot_t;

   typedef enum logic [1:0] {ACT_ADV, ACT_LU, ACT_RED, ACT_FRZ} act_t;

   slot_t sx, sm, sw;
   logic  x_ld, m_ld;
   act_t  act;

   logic [1:0][AW-1:0] rs_v;
   logic [1:0]         use_v;
   logic [1:0][1:0]    fwd_v;
   logic [1:0]         lu_v;
   logic               fwd_en;

   assign rs_v   = {id_rs2, id_rs1};
   assign use_v  = {id_rs2_use, id_rs1_use};
   assign fwd_en = !RST && id_valid && (act == ACT_ADV);
   assign fwd_a  = fwd_v[0];
   assign fwd_b  = fwd_v[1];

   for (genvar g = 0; g < 2; g++) begin : g_op
      phc_fwd_sel #(.AW(AW), .R0_ZERO(R0_ZERO)) u_sel (
         .en(fwd_en), .rs_use(use_v[g]), .rs(rs_v[g]),
         .x_v(sx.valid), .x_we(sx.we), .x_ld(x_ld), .x_rd(sx.rd),
         .m_v(sm.valid), .m_we(sm.we), .m_rd(sm.rd),
         .w_v(sw.valid), .w_we(sw.we), .w_rd(sw.rd),
         .sel(fwd_v[g]), .lu_hit(lu_v[g])
      );
   end

   // cycle action: a freeze masks a pending redirect, which reasserts afterwards
   always_comb begin
      act = ACT_ADV;
      if (mem_busy)                act = ACT_FRZ;
      else if (ex_redirect)        act = ACT_RED;
      else if (id_valid && |lu_v)  act = ACT_LU;
   end

   // pipeline control strobes; all quiet while reset is asserted
   always_comb begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      flush_id  = 1'b0;
      bubble_ex = 1'b0;
      pc_sel    = 1'b0;
      if (!RST) begin
         case (act)
            ACT_FRZ: begin stall_if = 1'b1; stall_id = 1'b1; end
            ACT_RED: begin pc_sel = 1'b1; flush_id = 1'b1; bubble_ex = 1'b1; end
            ACT_LU:  begin stall_if = 1'b1; stall_id = 1'b1; bubble_ex = 1'b1; end
            default: ;
         endcase
      end
   end

   // scoreboard shift and saturating perf counters
   always_ff @(posedge CLK) begin
      if (RST) begin
         sx        <= '0;
         sm        <= '0;
         sw        <= '0;
         x_ld      <= 1'b0;
         m_ld      <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         case (act)
            ACT_ADV: begin
               sw   <= sm;
               sm   <= sx;
               m_ld <= x_ld;
               sx   <= '{valid: id_valid, rd: id_rd, we: id_rd_we};
               x_ld <= id_is_load;
            end
            ACT_RED, ACT_LU: begin
               sw       <= sm;
               sm       <= sx;
               m_ld     <= x_ld;
               sx.valid <= 1'b0;
            end
            default: ;
         endcase
         if ((act == ACT_FRZ || act == ACT_LU) && !(&stall_cnt))
            stall_cnt <= stall_cnt + CW'(1);
         if (act == ACT_RED && !(&flush_cnt))
            flush_cnt <= flush_cnt + CW'(1);
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table for forwarding/load-use, then
// hand sequences for redirect, freeze, reset mid-stall and counter saturation.
module tb_pipe_hazard_ctrl;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       id_valid = 1'b0, id_rs1_use = 1'b0, id_rs2_use = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic       id_rd_we = 1'b0, id_is_load = 1'b0, ex_redirect = 1'b0, mem_busy = 1'b0;
   logic       stall_if, stall_id, flush_id, bubble_ex, pc_sel;
   logic [1:0] fwd_a, fwd_b;
   logic [15:0] stall_cnt, flush_cnt;
   logic [8:0] obs;

   pipe_hazard_ctrl #(.AW(5), .CW(16), .R0_ZERO(1'b1)) dut (
      .CLK(CLK), .RST(RST), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs1_use(id_rs1_use), .id_rs2(id_rs2), .id_rs2_use(id_rs2_use),
      .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
      .ex_redirect(ex_redirect), .mem_busy(mem_busy),
      .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .bubble_ex(bubble_ex),
      .pc_sel(pc_sel), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 CLK = ~CLK;

   assign obs = {stall_if, stall_id, flush_id, bubble_ex, pc_sel, fwd_a, fwd_b};

   // {stall_if, stall_id, flush_id, bubble_ex, pc_sel, fwd_a, fwd_b}
   localparam logic [8:0] O_LU = {5'b11010, 4'b0};
   localparam logic [8:0] O_RD = {5'b00111, 4'b0};
   localparam logic [8:0] O_FZ = {5'b11000, 4'b0};

   typedef struct {
      string      name;
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       we, ld, red, busy;
      logic [8:0] exp;
   } vec_t;

   vec_t       tbl[$];
   logic [8:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;

   function automatic logic [8:0] fw(int a, int b);
      return {5'b0, 2'(a), 2'(b)};
   endfunction

   function automatic vec_t mk(string n, logic v, int rs1, logic u1, int rs2, logic u2,
                               int rd, logic we, logic ld, logic red, logic busy,
                               logic [8:0] e);
      vec_t t;
      t.name = n; t.v = v; t.rs1 = 5'(rs1); t.u1 = u1; t.rs2 = 5'(rs2); t.u2 = u2;
      t.rd = 5'(rd); t.we = we; t.ld = ld; t.red = red; t.busy = busy; t.exp = e;
      return t;
   endfunction

   task automatic chk(string n, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", n, got, want);
      end
   endtask

   task automatic apply(input vec_t t);
      id_valid = t.v; id_rs1 = t.rs1; id_rs1_use = t.u1; id_rs2 = t.rs2; id_rs2_use = t.u2;
      id_rd = t.rd; id_rd_we = t.we; id_is_load = t.ld; ex_redirect = t.red; mem_busy = t.busy;
   endtask

   // one cycle: the edge retires the previous row, then this row is driven and checked
   task automatic step(input vec_t t);
      logic [8:0] e;
      @(posedge CLK);
      #1;
      apply(t);
      exp_q.push_back(t.exp);
      @(negedge CLK);
      e = exp_q.pop_front();
      chk(t.name, 32'(obs), 32'(e));
   endtask

   initial begin
      vec_t g;
      // forwarding chain, load-use, we=0 skipping, r0 exclusion, invalid ID
      tbl.push_back(mk("add_r3",      1, 1,1,  2,1,  3,1,0, 0,0, fw(0,0)));
      tbl.push_back(mk("fwd_x",       1, 3,1,  2,1,  6,1,0, 0,0, fw(1,0)));
      tbl.push_back(mk("fwd_m",       1, 3,1,  7,1,  8,1,0, 0,0, fw(2,0)));
      tbl.push_back(mk("fwd_w_nouse", 1, 3,1,  6,0,  9,1,0, 0,0, fw(3,0)));
      tbl.push_back(mk("fwd_none",    1, 3,1,  6,1, 10,0,0, 0,0, fw(0,3)));
      tbl.push_back(mk("ld_r5",       1,10,1,  0,0,  5,1,1, 0,0, fw(0,0)));
      tbl.push_back(mk("loaduse",     1, 9,1,  5,1, 11,1,0, 0,0, O_LU));
      tbl.push_back(mk("after_lu",    1, 9,1,  5,1, 11,1,0, 0,0, fw(0,2)));
      tbl.push_back(mk("fwd_w_ld",    1, 5,1,  0,0,  4,1,0, 0,0, fw(3,0)));
      tbl.push_back(mk("m_r11",       1, 0,0, 11,1,  4,0,0, 0,0, fw(0,2)));
      tbl.push_back(mk("m_r4",        1, 4,1,  0,0, 12,1,0, 0,0, fw(2,0)));
      tbl.push_back(mk("skip_we0",    1, 4,1, 12,1, 13,1,0, 0,0, fw(3,1)));
      tbl.push_back(mk("wr_r0",       1,13,1,  0,0,  0,1,0, 0,0, fw(1,0)));
      tbl.push_back(mk("r0_x",        1, 0,1, 12,1, 14,1,0, 0,0, fw(0,3)));
      tbl.push_back(mk("r0_m",        1, 0,1, 13,1, 15,0,0, 0,0, fw(0,3)));
      tbl.push_back(mk("ld_r0",       1, 0,0,  0,0,  0,1,1, 0,0, fw(0,0)));
      tbl.push_back(mk("r0_ld",       1, 0,1, 14,1, 16,1,0, 0,0, fw(0,3)));
      tbl.push_back(mk("id_inv",      0,16,1, 16,1,  0,0,0, 0,0, fw(0,0)));
      tbl.push_back(mk("m_r16",       1,16,1,  0,0, 17,1,0, 0,0, fw(2,0)));

      // reset state
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_out", 32'(obs), 32'(0));
      chk("rst_stall_cnt", 32'(stall_cnt), 32'(0));
      chk("rst_flush_cnt", 32'(flush_cnt), 32'(0));
      @(posedge CLK);
      #1 RST = 1'b0;

      foreach (tbl[i]) step(tbl[i]);
      chk("lu_stall_cnt", 32'(stall_cnt), 32'(1));
      chk("lu_flush_cnt", 32'(flush_cnt), 32'(0));

      // redirect overrides a load-use hazard in ID
      step(mk("ld_r20",      1, 0,0,  0,0, 20,1,1, 0,0, fw(0,0)));
      step(mk("redirect_lu", 1,20,1,  0,0, 21,1,0, 1,0, O_RD));
      step(mk("after_rd",    1,20,1, 17,1, 22,1,0, 0,0, fw(2,3)));
      chk("rd_stall_cnt", 32'(stall_cnt), 32'(1));
      chk("rd_flush_cnt", 32'(flush_cnt), 32'(1));

      // freeze masks redirect for 3 cycles, scoreboard holds
      for (int i = 0; i < 3; i++)
         step(mk("freeze",   1,22,1,  0,0, 23,1,0, 1,1, O_FZ));
      step(mk("redir_after_fz", 1,22,1, 0,0, 23,1,0, 1,0, O_RD));
      step(mk("fz_held",     1,22,1, 20,1, 23,0,0, 0,0, fw(2,0)));
      chk("fz_stall_cnt", 32'(stall_cnt), 32'(4));
      chk("fz_flush_cnt", 32'(flush_cnt), 32'(2));

      // reset asserted during a load-use stall
      step(mk("ld_r24",      1, 0,0,  0,0, 24,1,1, 0,0, fw(0,0)));
      g = mk("rst_lu", 1,24,1, 0,0, 25,1,0, 0,0, fw(0,0));
      @(posedge CLK);
      #1;
      apply(g);
      RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      exp_q.push_back(g.exp);
      @(negedge CLK);
      chk("post_rst_out", 32'(obs), 32'(exp_q.pop_front()));
      chk("post_rst_stall_cnt", 32'(stall_cnt), 32'(0));
      chk("post_rst_flush_cnt", 32'(flush_cnt), 32'(0));

      // saturate stall_cnt with a long freeze
      @(posedge CLK);
      #1;
      apply(mk("sat", 0, 0,0, 0,0, 0,0,0, 0,1, O_FZ));
      repeat (65534) @(posedge CLK);
      #1;
      chk("sat_fffe", 32'(stall_cnt), 32'h0000_fffe);
      chk("sat_out", 32'(obs), 32'(O_FZ));
      @(posedge CLK);
      #1;
      chk("sat_ffff", 32'(stall_cnt), 32'h0000_ffff);
      repeat (5) @(posedge CLK);
      #1;
      chk("sat_hold", 32'(stall_cnt), 32'h0000_ffff);
      chk("sat_flush_cnt", 32'(flush_cnt), 32'(0));
      mem_busy = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
